// File: rtl/pll_ctrl.sv
// pll_ctrl
// Sequencer for the device PLL. It handles power-down, reset, lock
// qualification, automatic relock after lock loss, and reprogramming of the
// dynamic dividers. All logic runs on the rising edge of the free-running
// reference clock.
//
// Ports
//   clkin       reference clock
//   reset       asynchronous, active-high reset
//   lock        PLL LOCK (asynchronous, synchronized internally)
//   cfg_req     divider change request, held by the requester until cfg_ack
//   cfg_idsel / cfg_fbdsel / cfg_mdsel / cfg_odsel0   requested divider values
//   cfg_ack     one-cycle pulse: request accepted, dividers updated
//   cfg_done    one-cycle pulse: first S_RUN entry after an accepted request
//   cfg_err     one-cycle pulse: S_FAIL reached after an accepted request
//   pll_pwd / pll_reset                to PLLPWD / RESET
//   idsel / fbdsel / mdsel / odsel0    to the dynamic divider pins
//   clk_en      to ENCLK0, high only while locked and running
//   ready / fail                       level status flags
//   lock_lost   one-cycle pulse on lock loss while running
//   lost_cnt    saturating count of lock-loss events
`timescale 1ns/1ps

module pll_ctrl #(
  parameter int          RST_CYCLES   = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 65536,
  parameter int          MAX_RETRY    = 3,
  parameter int          GATE_CYCLES  = 4,
  parameter logic [5:0]  IDSEL_DEF    = 6'd0,
  parameter logic [5:0]  FBDSEL_DEF   = 6'd0,
  parameter logic [6:0]  MDSEL_DEF    = 7'd0,
  parameter logic [6:0]  ODSEL0_DEF   = 7'd0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [6:0] cfg_mdsel,
  input  logic [6:0] cfg_odsel0,
  output logic       cfg_ack,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       pll_pwd,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [6:0] mdsel,
  output logic [6:0] odsel0,
  output logic       clk_en,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] lost_cnt
);

  // One phase counter serves S_PWD, S_RST and S_GATE; it only has to reach
  // the larger of the two lengths minus one before the state is left.
  localparam int PH_MAX = (RST_CYCLES > GATE_CYCLES) ? RST_CYCLES : GATE_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int ST_W   = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_PWD,
    S_RST,
    S_LOCK_WAIT,
    S_RUN,
    S_GATE,
    S_FAIL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              lock_meta;
  logic              lock_s;
  logic [PH_W-1:0]   ph_cnt;
  logic [ST_W-1:0]   stable_cnt;
  logic [TO_W-1:0]   tmo_cnt;
  logic [RT_W-1:0]   retry;
  logic              pending;
  logic              accept;
  logic              lost;
  logic              retry_inc;
  logic              state_change;
  logic              run_entry;
  logic              fail_entry;

  // Two-flop synchronizer; nothing else in the block looks at raw lock.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state logic. The stable check is made on the count the current
  // cycle would produce, so S_RUN follows exactly LOCK_STABLE good cycles.
  // Lock loss has priority over a request in S_RUN; the request stays
  // pending at the requester and is taken once S_RUN is re-entered.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    lost       = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      S_PWD: begin
        if (ph_cnt == PH_W'(RST_CYCLES - 1)) state_next = S_RST;
      end
      S_RST: begin
        if (ph_cnt == PH_W'(RST_CYCLES - 1)) state_next = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (lock_s && (stable_cnt == ST_W'(LOCK_STABLE - 1))) begin
          state_next = S_RUN;
        end else if (tmo_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          if (retry < RT_W'(MAX_RETRY)) begin
            retry_inc  = 1'b1;
            state_next = S_RST;
          end else begin
            state_next = S_FAIL;
          end
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost       = 1'b1;
          state_next = S_RST;
        end else if (cfg_req) begin
          accept     = 1'b1;
          state_next = S_GATE;
        end
      end
      S_GATE: begin
        if (ph_cnt == PH_W'(GATE_CYCLES - 1)) state_next = S_RST;
      end
      S_FAIL: begin
        if (cfg_req) begin
          accept     = 1'b1;
          state_next = S_RST;
        end
      end
      default: state_next = S_PWD;
    endcase
  end

  assign state_change = (state_next != state);
  assign run_entry    = (state_next == S_RUN)  && (state != S_RUN);
  assign fail_entry   = (state_next == S_FAIL) && (state != S_FAIL);

  // State register and per-state counters. Each counter restarts from zero
  // whenever its state is entered and is held at zero elsewhere.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= S_PWD;
      ph_cnt     <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      retry      <= '0;
    end else begin
      state <= state_next;

      if (state_change || !((state == S_PWD) || (state == S_RST) || (state == S_GATE)))
        ph_cnt <= '0;
      else
        ph_cnt <= ph_cnt + PH_W'(1);

      if (state_change || (state != S_LOCK_WAIT) || !lock_s)
        stable_cnt <= '0;
      else
        stable_cnt <= stable_cnt + ST_W'(1);

      if (state_change || (state != S_LOCK_WAIT))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TO_W'(1);

      if (run_entry || ((state == S_FAIL) && accept))
        retry <= '0;
      else if (retry_inc)
        retry <= retry + RT_W'(1);
    end
  end

  // PLL pins and status flags are registered from the next state so they
  // change cleanly together with the state register.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_pwd   <= 1'b1;
      pll_reset <= 1'b1;
      clk_en    <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      pll_pwd   <= (state_next == S_PWD);
      pll_reset <= (state_next == S_PWD) || (state_next == S_RST) || (state_next == S_FAIL);
      clk_en    <= (state_next == S_RUN);
      ready     <= (state_next == S_RUN);
      fail      <= (state_next == S_FAIL);
    end
  end

  // Divider latch, handshake pulses and lock-loss bookkeeping. The pending
  // flag ties each accepted request to exactly one done or err outcome.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      idsel     <= IDSEL_DEF;
      fbdsel    <= FBDSEL_DEF;
      mdsel     <= MDSEL_DEF;
      odsel0    <= ODSEL0_DEF;
      cfg_ack   <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      lock_lost <= 1'b0;
      lost_cnt  <= 8'd0;
      pending   <= 1'b0;
    end else begin
      cfg_ack   <= accept;
      cfg_done  <= pending && run_entry;
      cfg_err   <= pending && fail_entry;
      lock_lost <= lost;

      if (accept) begin
        idsel  <= cfg_idsel;
        fbdsel <= cfg_fbdsel;
        mdsel  <= cfg_mdsel;
        odsel0 <= cfg_odsel0;
      end

      if (accept)
        pending <= 1'b1;
      else if (run_entry || fail_entry)
        pending <= 1'b0;

      if (lost && (lost_cnt != 8'hFF))
        lost_cnt <= lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl
// Self-checking bench for pll_ctrl with small timing parameters. Expected
// edge numbers are derived arithmetically from the sequencing rules:
// reset/gate/wait phase lengths, the two-cycle lock synchronizer and the
// single decision edge that follows it.
`timescale 1ns/1ps

module tb_pll_ctrl;

  localparam int R  = 4;
  localparam int S  = 8;
  localparam int T  = 64;
  localparam int MR = 2;
  localparam int G  = 4;

  logic       clkin = 1'b0;
  logic       reset;
  logic       lock;
  logic       cfg_req;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [6:0] cfg_mdsel;
  logic [6:0] cfg_odsel0;
  logic       cfg_ack;
  logic       cfg_done;
  logic       cfg_err;
  logic       pll_pwd;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [6:0] mdsel;
  logic [6:0] odsel0;
  logic       clk_en;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] lost_cnt;

  int total = 0;
  int bad   = 0;

  // reference state: last accepted divider word and lock-loss count
  logic [25:0] model_div;
  int          model_lost;

  // results of one observation window (first edge index, or -1; counts)
  int          w_ack_j, w_done_j, w_err_j, w_lost_j, w_rise_j, w_off_j;
  int          w_fail_j, w_unfail_j, w_prst_j;
  int          w_ack_n, w_done_n, w_err_n, w_lost_n, w_prst_n;
  logic [25:0] w_div;

  pll_ctrl #(
    .RST_CYCLES   (R),
    .LOCK_STABLE  (S),
    .LOCK_TIMEOUT (T),
    .MAX_RETRY    (MR),
    .GATE_CYCLES  (G)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .lock       (lock),
    .cfg_req    (cfg_req),
    .cfg_idsel  (cfg_idsel),
    .cfg_fbdsel (cfg_fbdsel),
    .cfg_mdsel  (cfg_mdsel),
    .cfg_odsel0 (cfg_odsel0),
    .cfg_ack    (cfg_ack),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .pll_pwd    (pll_pwd),
    .pll_reset  (pll_reset),
    .idsel      (idsel),
    .fbdsel     (fbdsel),
    .mdsel      (mdsel),
    .odsel0     (odsel0),
    .clk_en     (clk_en),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .lost_cnt   (lost_cnt)
  );

  // 50 MHz reference clock
  always #10 clkin = ~clkin;

  // hard stop in case something hangs outside the bounded windows
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [5:0] id, input logic [5:0] fb,
                               input logic [6:0] md, input logic [6:0] od);
    cfg_req    = req;
    cfg_idsel  = id;
    cfg_fbdsel = fb;
    cfg_mdsel  = md;
    cfg_odsel0 = od;
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // random divider set; the model word is what the dividers must show after ack
  task automatic randomRequest(input logic req, output logic [25:0] word);
    logic [5:0] id, fb;
    logic [6:0] md, od;
    id = 6'($urandom_range(0, 63));
    fb = 6'($urandom_range(0, 63));
    md = 7'($urandom_range(0, 127));
    od = 7'($urandom_range(0, 127));
    applyStimulus(req, id, fb, md, od);
    word = {id, fb, md, od};
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_flags"},
                {23'd0, pll_pwd, pll_reset, clk_en, ready, fail, cfg_ack, cfg_done, cfg_err, lock_lost},
                {23'd0, 9'b1_1000_0000});
    checkOutput({tag, "_lost_cnt"}, {24'd0, lost_cnt}, 32'd0);
    checkOutput({tag, "_div"}, {6'd0, idsel, fbdsel, mdsel, odsel0}, 32'd0);
  endtask

  // Tick n edges, recording when events happen. lock is raised after edge
  // lock_up_j and cfg_req after edge req_j (0 = never); cfg_req is dropped
  // as soon as an ack is seen, like a real requester.
  task automatic observe(input int n, input int lock_up_j, input int req_j);
    logic prev_ready, prev_fail;
    w_ack_j = -1; w_done_j = -1; w_err_j = -1; w_lost_j = -1; w_rise_j = -1;
    w_off_j = -1; w_fail_j = -1; w_unfail_j = -1; w_prst_j = -1;
    w_ack_n = 0; w_done_n = 0; w_err_n = 0; w_lost_n = 0; w_prst_n = 0;
    w_div = '0;
    prev_ready = ready;
    prev_fail  = fail;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (cfg_ack) begin
        w_ack_n++;
        if (w_ack_j < 0) begin
          w_ack_j = j;
          w_div   = {idsel, fbdsel, mdsel, odsel0};
        end
        cfg_req = 1'b0;
      end
      if (cfg_done) begin w_done_n++; if (w_done_j < 0) w_done_j = j; end
      if (cfg_err)  begin w_err_n++;  if (w_err_j < 0)  w_err_j = j;  end
      if (lock_lost) begin w_lost_n++; if (w_lost_j < 0) w_lost_j = j; end
      if (pll_reset) begin w_prst_n++; if (w_prst_j < 0) w_prst_j = j; end
      if (ready && !prev_ready && (w_rise_j < 0)) w_rise_j = j;
      if (!clk_en && (w_off_j < 0)) w_off_j = j;
      if (fail && !prev_fail && (w_fail_j < 0)) w_fail_j = j;
      if (!fail && prev_fail && (w_unfail_j < 0)) w_unfail_j = j;
      prev_ready = ready;
      prev_fail  = fail;
      if (j == lock_up_j) lock = 1'b1;
      if (j == req_j) cfg_req = 1'b1;
    end
  endtask

  // Edge (relative to the lock drop) at which S_RUN is re-entered. The loss
  // is acted on 3 edges after the drop, R reset cycles follow, and then S
  // consecutive synchronized-lock decisions are needed; synchronized lock is
  // back for the decision at edge d+3 when lock was low for d cycles.
  function automatic int relockJ(input int d);
    int first;
    first = ((3 + R + 1) > (d + 3)) ? (3 + R + 1) : (d + 3);
    return first + S - 1;
  endfunction

  // Edge of S_FAIL entry when S_RST was entered at edge j0 with lock low.
  function automatic int failJ(input int j0);
    return j0 + R + (MR + 1) * T + MR * R;
  endfunction

  function automatic int satInc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic doReset();
    reset   = 1'b1;
    cfg_req = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    model_lost = 0;
    model_div  = '0;
  endtask

  initial begin
    logic [25:0] word;
    int          d;
    int          fail_edge;
    logic        exp_reset;
    logic        in_wait;

    lock  = 1'b1;
    reset = 1'b1;
    applyStimulus(1'b0, 6'd0, 6'd0, 7'd0, 7'd0);
    model_div  = '0;
    model_lost = 0;

    // reset state, then power-up sequence with lock present throughout
    repeat (3) tick();
    checkResetValues("reset");
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("powerup_k%0d", k), {28'd0, pll_pwd, pll_reset, ready, clk_en},
                  {28'd0, (k < R), (k < 2 * R), (k >= 2 * R + S), (k >= 2 * R + S)});
    end

    // single-cycle and longer lock drops in S_RUN, enough to saturate lost_cnt
    for (int i = 1; i <= 300; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d    = $urandom_range(1, 8);
      lock = 1'b0;
      observe(24, d, 0);
      model_lost = satInc(model_lost);
      checkOutput("loss_pulse_edge", w_lost_j, 3);
      checkOutput("loss_pulse_count", w_lost_n, 1);
      checkOutput("loss_clk_off_edge", w_off_j, 3);
      checkOutput("loss_relock_edge", w_rise_j, relockJ(d));
      checkOutput("loss_lost_cnt", {24'd0, lost_cnt}, model_lost);
    end

    // divider reprogramming from S_RUN; first set is the fixed example
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        applyStimulus(1'b1, 6'd3, 6'd5, 7'd20, 7'd40);
        word = {6'd3, 6'd5, 7'd20, 7'd40};
      end else begin
        randomRequest(1'b1, word);
      end
      observe(24, 0, 0);
      model_div = word;
      checkOutput("cfg_ack_edge", w_ack_j, 1);
      checkOutput("cfg_ack_count", w_ack_n, 1);
      checkOutput("cfg_div_at_ack", {6'd0, w_div}, {6'd0, model_div});
      checkOutput("cfg_clk_off_edge", w_off_j, 1);
      checkOutput("cfg_reset_start", w_prst_j, 1 + G);
      checkOutput("cfg_reset_len", w_prst_n, R);
      checkOutput("cfg_done_edge", w_done_j, 1 + G + R + S);
      checkOutput("cfg_done_count", w_done_n, 1);
      checkOutput("cfg_div_hold", {6'd0, idsel, fbdsel, mdsel, odsel0}, {6'd0, model_div});
    end

    // request arriving on the very edge lock loss is acted on
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(1, 4);
      randomRequest(1'b0, word);
      lock = 1'b0;
      observe(relockJ(d) + 1 + G + R + S + 4, d, 2);
      model_lost = satInc(model_lost);
      model_div  = word;
      checkOutput("race_lost_edge", w_lost_j, 3);
      checkOutput("race_ack_edge", w_ack_j, relockJ(d) + 1);
      checkOutput("race_ack_count", w_ack_n, 1);
      checkOutput("race_div", {6'd0, w_div}, {6'd0, model_div});
      checkOutput("race_done_edge", w_done_j, relockJ(d) + 1 + G + R + S);
      checkOutput("race_done_count", w_done_n, 1);
    end
    checkOutput("race_lost_cnt", {24'd0, lost_cnt}, model_lost);

    // permanent lock loss from S_RUN ends in S_FAIL, no request outstanding
    lock = 1'b0;
    observe(failJ(3) + 3, 0, 0);
    model_lost = satInc(model_lost);
    checkOutput("tofail_fail_edge", w_fail_j, failJ(3));
    checkOutput("tofail_err_count", w_err_n, 0);
    checkOutput("tofail_ready_rise", w_rise_j, -1);
    checkOutput("tofail_pll_reset", {31'd0, pll_reset}, 1);

    // leave S_FAIL with a request while lock is back: full relock, one done
    lock = 1'b1;
    randomRequest(1'b1, word);
    observe(20, 0, 0);
    model_div = word;
    checkOutput("failcfg_ack_edge", w_ack_j, 1);
    checkOutput("failcfg_unfail_edge", w_unfail_j, 1);
    checkOutput("failcfg_div", {6'd0, w_div}, {6'd0, model_div});
    checkOutput("failcfg_done_edge", w_done_j, 1 + R + S);
    checkOutput("failcfg_err_count", w_err_n, 0);

    // back to S_FAIL, then request with lock still absent: one cfg_err
    lock = 1'b0;
    observe(failJ(3) + 3, 0, 0);
    model_lost = satInc(model_lost);
    checkOutput("refail_fail_edge", w_fail_j, failJ(3));
    randomRequest(1'b1, word);
    fail_edge = failJ(1);
    observe(fail_edge + 5, 0, 0);
    model_div = word;
    checkOutput("failerr_ack_edge", w_ack_j, 1);
    checkOutput("failerr_div", {6'd0, w_div}, {6'd0, model_div});
    checkOutput("failerr_unfail_edge", w_unfail_j, 1);
    checkOutput("failerr_fail_edge", w_fail_j, fail_edge);
    checkOutput("failerr_err_edge", w_err_j, fail_edge);
    checkOutput("failerr_err_count", w_err_n, 1);
    checkOutput("failerr_done_count", w_done_n, 0);

    // recover, then assert reset in the middle of S_GATE
    lock = 1'b1;
    randomRequest(1'b1, word);
    observe(20, 0, 0);
    checkOutput("recover_done_edge", w_done_j, 1 + R + S);
    randomRequest(1'b1, word);
    tick();
    checkOutput("gate_ack", {31'd0, cfg_ack}, 1);
    cfg_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkResetValues("midgate");
    tick();
    tick();
    reset      = 1'b0;
    model_lost = 0;
    model_div  = '0;
    observe(30, 0, 0);
    checkOutput("postreset_done_count", w_done_n, 0);
    checkOutput("postreset_err_count", w_err_n, 0);
    checkOutput("postreset_ready_edge", w_rise_j, 2 * R + S);

    // lock absent from reset: three timeout windows, then S_FAIL
    lock = 1'b0;
    doReset();
    fail_edge = failJ(R);
    for (int k = 1; k <= fail_edge + 10; k++) begin
      tick();
      in_wait   = (k >= 2 * R) && (k < fail_edge) && (((k - 2 * R) % (T + R)) < T);
      exp_reset = !in_wait;
      checkOutput($sformatf("nolock_k%0d", k),
                  {27'd0, pll_pwd, pll_reset, ready, fail, cfg_err},
                  {27'd0, (k < R), exp_reset, 1'b0, (k >= fail_edge), 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
